// File: rtl/mic_capture_pkg.sv
// mic_capture_pkg: shared types and constants for the PDM microphone
// capture front end.
//   state_t      capture FSM states (IDLE, ARM, CAPTURE)
//   *_DEF        default values for the DIV / WORD_W / NWORDS parameters
//   DCNT_W       width of the mclk divider counter
//   WCNT_W       width of the recorded-word counter
//   bcnt_width() width of the bit-within-word counter for a given word size
package mic_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  localparam int DIV_DEF    = 25;
  localparam int WORD_W_DEF = 8;
  localparam int NWORDS_DEF = 4096;

  localparam int DCNT_W = 10;
  localparam int WCNT_W = 16;

  function automatic int bcnt_width(input int word_w);
    return (word_w > 1) ? $clog2(word_w) : 1;
  endfunction

endpackage

// File: rtl/mic_clkgen.sv
// mic_clkgen: free-running microphone bit-clock divider.
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-low reset
//   mclk   out  registered bit clock, f_clk / (2*DIV), starts low
//   stick  out  sample tick: last system cycle of the mclk high phase
module mic_clkgen
  import mic_capture_pkg::*;
#(
  parameter int DIV = DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  output logic mclk,
  output logic stick
);

  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DIV - 1);

  logic [DCNT_W-1:0] dcnt;
  logic              wrap;

  assign wrap = (dcnt == DCNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dcnt <= '0;
      mclk <= 1'b0;
    end else if (wrap) begin
      dcnt <= '0;
      mclk <= ~mclk;
    end else begin
      dcnt <= dcnt + DCNT_W'(1);
    end
  end

  // Sampling at the end of the high phase leaves the mic a full half
  // period to settle its data after the preceding rising edge.
  assign stick = wrap & mclk;

endmodule

// File: rtl/mic_capture.sv
// mic_capture: PDM microphone capture front end. Generates mclk, samples
// doutmic once per mclk period, packs bits MSB-first (oldest bit in MSB)
// into WORD_W-bit words and writes a fixed-length recording to the FIFO.
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   start      in   begin a recording (accepted in IDLE only)
//   stop       in   end early at the next word boundary
//   mclk       out  microphone bit clock
//   doutmic    in   PDM data from the microphone
//   fifo_din   out  packed word, valid while fifo_wr is high
//   fifo_wr    out  one-cycle FIFO write strobe
//   fifo_full  in   FIFO full flag, looked at in the write cycle only
//   busy       out  high in ARM and CAPTURE
//   done       out  one-cycle pulse at the end of a recording
//   overrun    out  sticky flag: a word was dropped on fifo_full
module mic_capture
  import mic_capture_pkg::*;
#(
  parameter int DIV    = DIV_DEF,
  parameter int WORD_W = WORD_W_DEF,
  parameter int NWORDS = NWORDS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  output logic              mclk,
  input  logic              doutmic,
  output logic [WORD_W-1:0] fifo_din,
  output logic              fifo_wr,
  input  logic              fifo_full,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam int                BCNT_W    = bcnt_width(WORD_W);
  localparam logic [BCNT_W-1:0] BIT_LAST  = BCNT_W'(WORD_W - 1);
  localparam logic [WCNT_W-1:0] WORD_LAST = WCNT_W'(NWORDS - 1);

  state_t              state;
  state_t              state_nx;
  logic                stick;
  logic                stop_pend;
  logic                word_rdy;
  logic                capture_bit;
  logic                ending;
  logic [WORD_W-1:0]   sh;
  logic [WORD_W-1:0]   sh_nx;
  logic [BCNT_W-1:0]   bcnt;
  logic [WCNT_W-1:0]   wcnt;

  mic_clkgen #(
    .DIV (DIV)
  ) u_clkgen (
    .clk   (clk),
    .reset (reset),
    .mclk  (mclk),
    .stick (stick)
  );

  assign sh_nx = {sh[WORD_W-2:0], doutmic};

  // The first tick seen in ARM is already bit 0 of word 0; a stop in the
  // same cycle wins and nothing is captured.
  assign capture_bit = stick && (((state == ARM) && !stop) || (state == CAPTURE));

  // A completed word closes the recording if it is the last one or a stop
  // is pending (including one arriving in the write cycle itself).
  assign ending = (wcnt == WORD_LAST) || stop_pend || stop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = ARM;
      ARM: begin
        if (stop) begin
          state_nx = IDLE;
        end else if (stick) begin
          state_nx = CAPTURE;
        end
      end
      CAPTURE: if (word_rdy && ending) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Write and done strobes are decoded in the cycle after the last bit of
  // a word, so fifo_full is evaluated in the same cycle as the strobe.
  always_comb begin
    busy    = (state != IDLE);
    fifo_wr = (state == CAPTURE) && word_rdy && !fifo_full;
    done    = ((state == ARM) && stop) ||
              ((state == CAPTURE) && word_rdy && ending);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh        <= '0;
      bcnt      <= '0;
      wcnt      <= '0;
      word_rdy  <= 1'b0;
      stop_pend <= 1'b0;
      overrun   <= 1'b0;
      fifo_din  <= '0;
    end else begin
      word_rdy <= 1'b0;

      if (state == IDLE) begin
        if (start) begin
          bcnt      <= '0;
          wcnt      <= '0;
          stop_pend <= 1'b0;
          overrun   <= 1'b0;
        end
      end else if (stop) begin
        stop_pend <= 1'b1;
      end

      if (capture_bit) begin
        sh <= sh_nx;
        if (bcnt == BIT_LAST) begin
          bcnt     <= '0;
          word_rdy <= 1'b1;
          fifo_din <= sh_nx;
        end else begin
          bcnt <= bcnt + BCNT_W'(1);
        end
      end

      // Dropped words still count: the recording length is fixed in time.
      if ((state == CAPTURE) && word_rdy) begin
        wcnt <= wcnt + WCNT_W'(1);
        if (fifo_full) begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/mic_capture.md
# mic_capture

PDM microphone capture front end: generates the microphone bit clock, samples the 1-bit `doutmic` stream, packs it MSB-first into bytes and writes a fixed-length recording into the audio FIFO. It sits directly upstream of the audio FIFO / PWM playback stage, replacing the free-running bit-wide FIFO write with a counted, framed byte capture under `start`/`done` control.

## Interface

Parameters:
- `DIV`, 25, system-clock cycles per `mclk` half period (`mclk` = f_clk / (2·DIV)); legal range 2..1023.
- `WORD_W`, 8, bits per packed word.
- `NWORDS`, 4096, words per recording; legal range 1..65535.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a recording; sampled in IDLE only.
- `stop`  in  1  end recording early at the next word boundary.
- `mclk`  out  1  microphone bit clock, registered.
- `doutmic`  in  1  PDM data from microphone.
- `fifo_din`  out  WORD_W  packed word, MSB = oldest bit.
- `fifo_wr`  out  1  one-cycle write strobe, `fifo_din` valid same cycle.
- `fifo_full`  in  1  FIFO full flag.
- `busy`  out  1  high in ARM and CAPTURE.
- `done`  out  1  one-cycle pulse at end of recording.
- `overrun`  out  1  sticky: at least one word dropped due to `fifo_full`; cleared on accepted `start`.

## Operation

- Divider: counter `dcnt` 0..DIV-1; at DIV-1 wraps to 0 and toggles `mclk`. Runs continuously in all states (mic needs a stable clock).
- Sample tick `stick` = (`dcnt`==DIV-1 && `mclk`==1): `doutmic` sampled at end of the high phase, one cycle before falling edge.
- States: IDLE → ARM on `start`; ARM → CAPTURE on first `stick`(that bit is captured as bit 0 of word 0); CAPTURE → IDLE when word count reaches NWORDS or when a word completes with stop pending.
- Shifter: on each `stick` in CAPTURE, `sh <= {sh[WORD_W-2:0], doutmic}`, bit counter +1. When bit counter wraps (WORD_W bits), next cycle: `fifo_din <= sh`, `fifo_wr <= !fifo_full`; if `fifo_full`, `overrun <= 1`, word discarded. Word counter increments in both cases (recording length is time-fixed).
- `stop`: latched into `stop_pend` any cycle in ARM/CAPTURE; in ARM returns straight to IDLE with `done` pulse and zero words; in CAPTURE finishes the current word then ends. Partial words are never written.
- `start` while `busy` ignored. `start` and `stop` together in IDLE: start accepted, stop ignored.
- Completion: `done` pulses in the same cycle the final `fifo_wr` (or dropped write) occurs; `busy` low the next cycle.

## Timing

- Reset values: `mclk`=0, `dcnt`=0, `fifo_din`=0, `fifo_wr`=0, `busy`=0, `done`=0, `overrun`=0, state IDLE, all counters 0.
- `start` → `busy` high: 1 cycle. ARM → first sample: ≤ 2·DIV cycles.
- Word latency: `fifo_wr` exactly 1 clk after the WORD_W-th `stick`. Write spacing: WORD_W·2·DIV clk.
- `fifo_full` is sampled in the write cycle only; no retry.
- Reset mid-recording: all state cleared immediately; no `done`, no partial write.
- Counters width: bit counter clog2(WORD_W), word counter 16 bits, `dcnt` 10 bits.

## Structure

- Package `mic_capture_pkg`: state enum (IDLE, ARM, CAPTURE), default constants for DIV/WORD_W/NWORDS, counter widths.
- One sub-module `mic_clkgen`: divider producing `mclk` and `stick`; parent holds FSM, shifter, counters.

## Test plan

- Clock: DIV=2 → `mclk` period 4 clk, 50 % duty, `stick` once per 4 clk, running from reset release in IDLE.
- Capture: DIV=2, NWORDS=2, `doutmic` pattern 1,0,1,1,0,0,1,0, 0xFF-bits → `fifo_din`=0xB2 then 0xFF, two `fifo_wr` pulses 32 clk apart, `done` with second write, `overrun`=0.
- Full: hold `fifo_full`=1 during word 1 of 3 → only words 0 and 2 written, `overrun`=1, `done` after third word slot; next `start` clears `overrun`.
- Stop: assert `stop` after bit 3 of word 1, NWORDS=10 → word 1 completes and is written, `done` pulse, no word 2, `busy` low next cycle.
- Reset: pull `reset` low mid-word 5 → all outputs to reset values same cycle, no `done`; after release `start` records from word 0.
- Ignored start: pulse `start` during CAPTURE → word count and `done` timing unchanged.
